bcd_counter_scan: RTL and testbench
===================================

// Module: bcd_counter_scan
// PURPOSE
//  Key-controlled DIGITS-wide BCD up/down counter with time-multiplexed 7-segment output and status LEDs.
//  Generalises the two-digit key/seg/led board top: digit count, rates and output polarity are parametrised.
//  Adds debounce, pause/resume, direction and clear. Sits directly under the board top, driving the pins.
// PARAMETERS
//  DIGITS        2        number of BCD digits / com lines (1..8)
//  DEBOUNCE_CYC  20000    cycles a raw key must be stable before the debounced level changes (>=2)
//  SCAN_CYC      50000    cycles each digit stays selected (>=2)
//  TICK_CYC      1000000  cycles between count steps while running (>=2)
//  COM_ACT_LOW   1        1: com active-low, 0: active-high
//  SEG_ACT_LOW   1        1: seg active-low, 0: active-high; seg[7]=dp, seg[6:0]=g..a
// PORTS
//  sys_clk  in   1         system clock; all logic on rising edge
//  sys_rst  in   1         asynchronous, active-low reset
//  key      in   3         raw pushbuttons, 1=pressed: [0] start/pause, [1] clear, [2] direction toggle
//  com      out  DIGITS    digit select, one-hot active per COM_ACT_LOW
//  seg      out  8         segment pattern of the selected digit
//  led      out  4         [0] running, [1] paused, [2] counting down, [3] wrapped (sticky)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, count=0, dir=up, wrap=0, scan idx=0, all timers 0;
//   com all inactive, seg all off, led=4'b0000. Every output is a register.
//  Keys: 2-FF synchroniser per key, then debounce counter. Debounced level changes only after
//   DEBOUNCE_CYC consecutive cycles of a differing synced level. Rising edge of debounced level -> 1-cycle press.
//   Press latency from raw edge: 2 (sync) + DEBOUNCE_CYC + 1 cycles. Glitches shorter than DEBOUNCE_CYC are ignored.
//  FSM: IDLE --start--> RUN; RUN --start--> PAUSE; PAUSE --start--> RUN;
//   any --clear--> IDLE with count=0, wrap=0, tick timer=0. dir unchanged by clear.
//  Tick timer counts only in RUN and resets to 0 on entering RUN. Step on cycle where timer==TICK_CYC-1.
//   First step therefore comes TICK_CYC cycles after the RUN entry.
//  Step: BCD +1 or -1 across all digits with per-digit carry/borrow.
//   Wrap: 10^DIGITS-1 -> 0 (up) and 0 -> 10^DIGITS-1 (down); either wrap sets wrap (held until clear/reset).
//  Direction press toggles dir in any state and takes effect on the next step.
//  Same-cycle priority: clear > start > step. A step coinciding with a start press is still applied.
//   A step coinciding with a clear press is discarded. Direction press plus step: the step uses the old dir.
//  Scan: idx advances every SCAN_CYC cycles, DIGITS-1 -> 0. Runs in every state, including IDLE.
//   First com/seg update comes SCAN_CYC cycles after reset release. idx 0 = least-significant digit = com[0].
//   com/seg update on the same edge, from the count value registered that cycle. dp always off. No blanking of leading zeros.
//  led[0]=(RUN), led[1]=(PAUSE), led[2]=dir down, led[3]=wrap; registered, 1 cycle after the cause.
//  Mid-operation reset: immediate return to reset values regardless of state or in-flight debounce.
// STRUCTURE
//  Shared header bcd_scan_defs.vh: FSM state encodings (IDLE/RUN/PAUSE), 7-seg decode constants for 0-9,
//   KEY_START/KEY_CLEAR/KEY_DIR index defines.
//  Sub-module key_debounce (param DEBOUNCE_CYC): sync + debounce + press pulse, instantiated once per key.
//  Remaining logic (FSM, BCD counter, scan/decode, LED regs) stays inline in this module.
// TESTING  (bench params: DIGITS=2, DEBOUNCE_CYC=4, SCAN_CYC=3, TICK_CYC=10, both polarities active-low)
//  1 Reset: hold sys_rst=0 -> com=2'b11, seg=8'hFF, led=0.
//    Release -> after 3 cycles com=2'b10, seg=8'hC0 ('0').
//    Then com=2'b01, then 2'b10 again.
//  2 Debounce: key[0] high for 3 cycles -> no state change.
//    key[0] high for 20 cycles -> RUN one press pulse later, led=4'b0001.
//    Release, press again -> PAUSE, led=4'b0010.
//  3 Counting: RUN for 1000 cycles -> count=99, display digits 9/9.
//    Next step -> count=00, led[3]=1.
//    Clear press -> count=00, led=4'b0000, IDLE.
//  4 Down/wrap: toggle dir in IDLE (led[2]=1), start -> first step at RUN+10 gives count=99, led[3]=1.
//    Next step -> count=98.
//  5 Simultaneous: press clear and start in the same cycle -> IDLE, count=0.
//    Align clear press with a step cycle -> count stays 0.
//  6 Reset mid-RUN at count=47 -> all outputs return to reset values within the same cycle.
//    Re-run -> counts from 0.

Source files
------------

// File: rtl/bcd_counter_scan_pkg.sv
// Shared types and constants for the key-controlled BCD counter with
// multiplexed 7-segment output.
package bcd_counter_scan_pkg;

  // Control FSM states; the encoding is also exported on the debug port
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Key bit positions on the raw key bus
  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;
  localparam int KEY_DIR   = 2;

  // Active-high segment pattern g..a for one BCD digit (non-BCD codes dark)
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_counter_scan_key_debounce.sv
// One pushbutton: two-flop synchroniser, stability-counter debounce and a
// single-cycle pulse on each rising edge of the debounced level.
module bcd_counter_scan_key_debounce #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int            CW   = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Level flips only after DEBOUNCE_CYC consecutive differing synced samples;
  // press is the registered rising edge of that level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_scan.sv
// DIGITS-wide BCD up/down counter driven by three debounced keys, with a
// time-multiplexed 7-segment display and status LEDs. All outputs registered.
module bcd_counter_scan
  import bcd_counter_scan_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int SCAN_CYC     = 50000,
  parameter int TICK_CYC     = 1000000,
  parameter bit COM_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW  = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [2:0]        key,
  output logic [DIGITS-1:0] com,
  output logic [7:0]        seg,
  output logic [3:0]        led,
  output state_e            fsm_state
);

  localparam int            TW         = $clog2(TICK_CYC);
  localparam int            SW         = $clog2(SCAN_CYC);
  localparam int            IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYC - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [2:0]          press;
  state_e              state;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] stepped;
  logic                dir;
  logic                wrap;
  logic [TW-1:0]       tick_cnt;
  logic                step;
  logic                step_wrap;
  logic                chain;
  logic [3:0]          digit;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic [3:0]          cur_digit;
  logic [DIGITS-1:0]   onehot;

  for (genvar k = 0; k < 3; k++) begin : g_key
    bcd_counter_scan_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
      .clk   (sys_clk),
      .rst_n (sys_rst),
      .raw   (key[k]),
      .press (press[k])
    );
  end

  assign step      = (state == ST_RUN) && (tick_cnt == TICK_LAST);
  assign fsm_state = state;

  // Count plus or minus one with carry/borrow rippling through the digits
  always_comb begin
    stepped = count;
    chain   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (chain) begin
        if (!dir) begin
          if (digit == 4'd9) digit = 4'd0;
          else begin
            digit = digit + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (digit == 4'd0) digit = 4'd9;
          else begin
            digit = digit - 4'd1;
            chain = 1'b0;
          end
        end
      end
      stepped[4*i +: 4] = digit;
    end
    step_wrap = chain;
  end

  // Control FSM with counter, direction, sticky wrap and tick timer.
  // Clear beats start beats step; a step alongside start still lands.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      dir      <= 1'b0;
      wrap     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      if (press[KEY_DIR]) dir <= ~dir;
      if (press[KEY_CLEAR]) begin
        state    <= ST_IDLE;
        count    <= '0;
        wrap     <= 1'b0;
        tick_cnt <= '0;
      end else begin
        if (step) begin
          count <= stepped;
          if (step_wrap) wrap <= 1'b1;
        end
        if (state == ST_RUN) tick_cnt <= step ? '0 : tick_cnt + 1'b1;
        if (press[KEY_START]) begin
          case (state)
            ST_RUN:  state <= ST_PAUSE;
            default: begin
              state    <= ST_RUN;
              tick_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

  // Status LEDs mirror the registered control state one cycle later
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) led <= 4'b0000;
    else          led <= {wrap, dir, state == ST_PAUSE, state == ST_RUN};
  end

  assign cur_digit = count[4*idx +: 4];
  assign onehot    = DIGITS'(1) << idx;

  // Digit scan: every SCAN_CYC cycles show digit idx, then move to the next
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      com      <= {DIGITS{COM_ACT_LOW}};
      seg      <= {8{SEG_ACT_LOW}};
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      com      <= COM_ACT_LOW ? ~onehot : onehot;
      seg      <= SEG_ACT_LOW ? ~{1'b0, seg_decode(cur_digit)}
                              : {1'b0, seg_decode(cur_digit)};
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Bench for bcd_counter_scan: directed key sequences plus random key traffic,
// checked every cycle against a decimal-arithmetic model of the board.
module tb_bcd_counter_scan;
  import bcd_counter_scan_pkg::*;

  localparam int DEB  = 4;
  localparam int SCAN = 3;
  localparam int TICK = 10;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [2:0] key     = 3'b000;
  logic [1:0] com;
  logic [7:0] seg;
  logic [3:0] led;
  state_e     fsm_state;

  always #5 sys_clk = ~sys_clk;

  bcd_counter_scan #(
    .DIGITS(2), .DEBOUNCE_CYC(DEB), .SCAN_CYC(SCAN), .TICK_CYC(TICK),
    .COM_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key       (key),
    .com       (com),
    .seg       (seg),
    .led       (led),
    .fsm_state (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Active-low patterns for decimal digits 0..9, dp dark.
  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  bit   [2:0] m_s1, m_s2, m_lvl, m_lvl_d, m_press, pr;
  int         m_run [3];
  state_e     m_st;
  int         m_cnt, m_tmr, m_scnt, m_idx, old_cnt;
  bit         m_dir, m_wrap, stp;
  logic [1:0] m_com;
  logic [7:0] m_seg;
  logic [3:0] m_led;

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_press = '0;
      for (int k = 0; k < 3; k++) m_run[k] = 0;
      m_st = ST_IDLE; m_cnt = 0; m_dir = 0; m_wrap = 0; m_tmr = 0;
      m_scnt = 0; m_idx = 0;
      m_com = 2'b11; m_seg = 8'hFF; m_led = 4'b0000;
    end else begin
      old_cnt = m_cnt;
      pr      = m_press;
      m_led   = {m_wrap, m_dir, m_st == ST_PAUSE, m_st == ST_RUN};
      if (m_scnt == SCAN - 1) begin
        m_scnt = 0;
        m_com  = (m_idx == 0) ? 2'b10 : 2'b01;
        m_seg  = seg_tbl[(m_idx == 0) ? old_cnt % 10 : old_cnt / 10];
        m_idx  = 1 - m_idx;
      end else begin
        m_scnt++;
      end
      stp = (m_st == ST_RUN) && (m_tmr == TICK - 1);
      if (pr[1]) begin
        m_st = ST_IDLE; m_cnt = 0; m_wrap = 0; m_tmr = 0;
      end else begin
        if (stp) begin
          if (!m_dir) begin
            if (m_cnt == 99) m_wrap = 1;
            m_cnt = (m_cnt + 1) % 100;
          end else begin
            if (m_cnt == 0) m_wrap = 1;
            m_cnt = (m_cnt + 99) % 100;
          end
        end
        if (m_st == ST_RUN) m_tmr = stp ? 0 : m_tmr + 1;
        if (pr[0]) begin
          if (m_st == ST_RUN) m_st = ST_PAUSE;
          else begin
            m_st  = ST_RUN;
            m_tmr = 0;
          end
        end
      end
      if (pr[2]) m_dir = !m_dir;
      for (int k = 0; k < 3; k++) begin
        m_press[k] = m_lvl[k] & !m_lvl_d[k];
        m_lvl_d[k] = m_lvl[k];
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_lvl[k] = m_s2[k];
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = key;
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge sys_clk) begin
    check("com", com, m_com);
    check("seg", seg, m_seg);
    check("led", led, m_led);
    check("state", fsm_state, m_st);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic hold_key(input int k, input int n);
    key[k] = 1'b1;
    tick(n);
    key[k] = 1'b0;
    tick(DEB + 8);
  endtask

  task automatic wait_count(input int v, input int budget);
    int n;
    n = 0;
    while (m_cnt != v && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_count_timeout", n < budget, 1);
  endtask

  bit seen_lo, seen_hi;

  initial begin
    // 1: reset values and first scans
    repeat (3) @(negedge sys_clk);
    check("rst_com", com, 2'b11);
    check("rst_seg", seg, 8'hFF);
    check("rst_led", led, 4'b0000);
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("scan0_com", com, 2'b10);
    check("scan0_seg", seg, 8'hC0);
    tick(3);
    check("scan1_com", com, 2'b01);
    tick(3);
    check("scan2_com", com, 2'b10);

    // 2: debounce
    hold_key(0, 3);
    check("glitch_state", fsm_state, ST_IDLE);
    check("glitch_led", led, 4'b0000);
    hold_key(0, 20);
    check("run_led", led, 4'b0001);
    hold_key(0, 10);
    check("pause_led", led, 4'b0010);

    // 3: count up to 99 and wrap
    hold_key(1, 10);
    check("clr_led", led, 4'b0000);
    hold_key(0, 10);
    wait_count(99, 1500);
    repeat (3) @(posedge sys_clk);
    seen_lo = 0;
    seen_hi = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge sys_clk);
      check("digits_99", seg, 8'h90);
      if (com == 2'b10) seen_lo = 1;
      if (com == 2'b01) seen_hi = 1;
    end
    check("both_digits", {seen_hi, seen_lo}, 2'b11);
    #1;
    wait_count(0, 20);
    tick(2);
    check("wrap_led", led, 4'b1001);
    hold_key(1, 10);
    check("clear_led", led, 4'b0000);
    check("clear_state", fsm_state, ST_IDLE);

    // 4: down-count wrap
    hold_key(2, 10);
    check("dir_led", led, 4'b0100);
    hold_key(0, 10);
    wait_count(99, 40);
    tick(2);
    check("down_wrap_led", led, 4'b1101);
    wait_count(98, 20);

    // 5: clear and start together, then clear aligned with a step
    key[0] = 1'b1;
    key[1] = 1'b1;
    tick(DEB + 4);
    key = 3'b000;
    tick(DEB + 8);
    check("clr_start_state", fsm_state, ST_IDLE);
    check("clr_start_led", led, 4'b0100);
    key[0] = 1'b1;
    tick(10);
    key[1] = 1'b1;
    tick(2);
    key[0] = 1'b0;
    tick(6);
    key[1] = 1'b0;
    tick(DEB + 10);
    check("clr_step_state", fsm_state, ST_IDLE);
    check("clr_step_led", led, 4'b0100);

    // 6: reset in the middle of a run at 47
    hold_key(2, 10);
    hold_key(0, 10);
    wait_count(47, 600);
    #1;
    sys_rst = 1'b0;
    #1;
    check("mid_rst_com", com, 2'b11);
    check("mid_rst_seg", seg, 8'hFF);
    check("mid_rst_led", led, 4'b0000);
    check("mid_rst_state", fsm_state, ST_IDLE);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    tick(1);
    hold_key(0, 10);
    wait_count(3, 60);
    tick(2);
    check("rerun_led", led, 4'b0001);

    // random key traffic
    for (int i = 0; i < 60; i++) begin
      key = 3'($urandom_range(0, 7));
      tick($urandom_range(1, 25));
    end
    key = 3'b000;
    tick(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
